// File: rtl/dac_spi_tx_if.sv
// Sample/handshake and SPI pin bundle between the waveform generator, dac_spi_tx and the external DAC.
interface dac_spi_tx_if;
    logic [15:0] sample;
    logic        enable;
    logic        frame_start;
    logic        busy;
    logic        dac_sclk;
    logic        dac_cs_n;
    logic        dac_mosi;
    logic        dac_ldac_n;

    modport master (
        input  sample,
        input  enable,
        output frame_start,
        output busy,
        output dac_sclk,
        output dac_cs_n,
        output dac_mosi,
        output dac_ldac_n
    );

    modport slave (
        output sample,
        output enable,
        input  frame_start,
        input  busy,
        input  dac_sclk,
        input  dac_cs_n,
        input  dac_mosi,
        input  dac_ldac_n
    );
endinterface

// File: rtl/dac_spi_tx.sv
// Serialises one 16-bit sample per frame to an SPI DAC (CS framing, SCLK, MSB-first MOSI, LDAC strobe).
// Every output is a flop loaded with the value belonging to the state being entered.
module dac_spi_tx #(
    parameter int CLK_DIV   = 2,
    parameter int GAP_CYC   = 4,
    parameter bit TWOS_COMP = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    dac_spi_tx_if.master bus
);

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [15:0] MSB_FLIP = {TWOS_COMP, 15'd0};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP,
        LDAC
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] shreg_q, shreg_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic        ldac_n_q, ldac_n_d;
    logic        busy_q, busy_d;
    logic        frame_start_q, frame_start_d;

    logic [15:0] load_word;
    logic        start_load;

    assign load_word = bus.sample ^ MSB_FLIP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            gap_q         <= '0;
            shreg_q       <= '0;
            sclk_q        <= 1'b0;
            cs_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            ldac_n_q      <= 1'b1;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            gap_q         <= gap_d;
            shreg_q       <= shreg_d;
            sclk_q        <= sclk_d;
            cs_n_q        <= cs_n_d;
            mosi_q        <= mosi_d;
            ldac_n_q      <= ldac_n_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        gap_d         = gap_q;
        shreg_d       = shreg_q;
        sclk_d        = sclk_q;
        cs_n_d        = cs_n_q;
        mosi_d        = mosi_q;
        ldac_n_d      = 1'b1;
        busy_d        = busy_q;
        frame_start_d = 1'b0;
        start_load    = 1'b0;

        case (state_q)
            IDLE: begin
                start_load = bus.enable;
            end
            LOAD: begin
                state_d = SHIFT;
                div_d   = '0;
                bit_d   = '0;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // A falling SCLK edge is where the next bit is presented, so MOSI holds through each high phase.
                    if (sclk_q) begin
                        if (bit_q == 4'd15) begin
                            state_d = GAP;
                            gap_d   = '0;
                            sclk_d  = 1'b0;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                        end else begin
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_q[14];
                            bit_d   = bit_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d  = LDAC;
                    ldac_n_d = 1'b0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            LDAC: begin
                if (bus.enable) begin
                    start_load = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Entered from IDLE or straight from LDAC, so back-to-back frames need no idle cycle.
        if (start_load) begin
            state_d       = LOAD;
            shreg_d       = load_word;
            mosi_d        = load_word[15];
            cs_n_d        = 1'b0;
            sclk_d        = 1'b0;
            busy_d        = 1'b1;
            frame_start_d = 1'b1;
        end
    end

    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.dac_sclk    = sclk_q;
    assign bus.dac_cs_n    = cs_n_q;
    assign bus.dac_mosi    = mosi_q;
    assign bus.dac_ldac_n  = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: three parameterisations, a pin-level SPI monitor and a word scoreboard.
module tb_dac_spi_tx;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        int          cs_low;
        int          sclk_hi;
        int          ones;
        int          unstable;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    int   sel;
    int   total = 0;
    int   bad   = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    dac_spi_tx_if if0 ();
    dac_spi_tx_if if1 ();
    dac_spi_tx_if if2 ();

    dac_spi_tx u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    dac_spi_tx #(.TWOS_COMP(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    dac_spi_tx #(.CLK_DIV(1), .GAP_CYC(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

    logic m_fs, m_busy, m_sclk, m_cs_n, m_mosi, m_ldac_n;

    always_comb begin
        case (sel)
            0: begin
                m_fs = if0.frame_start; m_busy = if0.busy; m_sclk = if0.dac_sclk;
                m_cs_n = if0.dac_cs_n; m_mosi = if0.dac_mosi; m_ldac_n = if0.dac_ldac_n;
            end
            1: begin
                m_fs = if1.frame_start; m_busy = if1.busy; m_sclk = if1.dac_sclk;
                m_cs_n = if1.dac_cs_n; m_mosi = if1.dac_mosi; m_ldac_n = if1.dac_ldac_n;
            end
            default: begin
                m_fs = if2.frame_start; m_busy = if2.busy; m_sclk = if2.dac_sclk;
                m_cs_n = if2.dac_cs_n; m_mosi = if2.dac_mosi; m_ldac_n = if2.dac_ldac_n;
            end
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    frame_t      obs_q[$];
    logic [15:0] exp_q[$];
    int          gap_q[$];
    int unsigned fs_q[$];
    frame_t      cur;
    logic        prev_sclk = 1'b0;
    logic        prev_cs_n = 1'b1;
    logic        prev_mosi = 1'b0;
    bit          in_gap    = 1'b0;
    int          gap_cnt   = 0;
    int          ldac_cnt  = 0;

    // Pin-level monitor on the selected instance: rebuilds words from SCLK rising edges and measures framing.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            cur       = '{default: 0};
            in_gap    = 1'b0;
            prev_sclk = 1'b0;
            prev_cs_n = 1'b1;
            prev_mosi = 1'b0;
        end else begin
            if (m_fs) fs_q.push_back(cyc);
            if (!m_ldac_n) ldac_cnt++;
            if (!m_cs_n) begin
                cur.cs_low++;
                if (m_mosi) cur.ones++;
                if (m_sclk) begin
                    cur.sclk_hi++;
                    if (!prev_sclk) begin
                        cur.word = {cur.word[14:0], m_mosi};
                        cur.nbits++;
                    end else if (m_mosi !== prev_mosi) begin
                        cur.unstable = 1;
                    end
                end
            end else if (!prev_cs_n) begin
                obs_q.push_back(cur);
                cur     = '{default: 0};
                in_gap  = 1'b1;
                gap_cnt = 1;
            end else if (in_gap) begin
                if (!m_ldac_n) begin
                    gap_q.push_back(gap_cnt);
                    in_gap = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            prev_sclk = m_sclk;
            prev_cs_n = m_cs_n;
            prev_mosi = m_mosi;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The bench models TWOS_COMP only for u1, the one instance built with it.
    task automatic apply_stimulus(input logic [15:0] s, input bit push);
        case (sel)
            0:       if0.sample = s;
            1:       if1.sample = s;
            default: if2.sample = s;
        endcase
        if (push) exp_q.push_back(s ^ ((sel == 1) ? 16'h8000 : 16'h0000));
    endtask

    task automatic set_enable(input logic e);
        case (sel)
            0:       if0.enable = e;
            1:       if1.enable = e;
            default: if2.enable = e;
        endcase
    endtask

    task automatic flush();
        obs_q.delete();
        exp_q.delete();
        gap_q.delete();
        fs_q.delete();
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output("frame_arrival", 32'(obs_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (m_busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output("idle_busy", 32'(m_busy), 32'd0);
        check_output("idle_cs_n", 32'(m_cs_n), 32'd1);
    endtask

    task automatic check_gap(input int exp_gap, input int budget);
        int k = 0;
        int g = -1;
        while (gap_q.size() == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (gap_q.size() > 0) g = gap_q.pop_front();
        check_output("cs_gap_before_ldac", 32'(g), 32'(exp_gap));
    endtask

    task automatic check_frame(input int cd);
        frame_t      f;
        logic [15:0] w;
        f = '{default: 0};
        f.word = 16'hxxxx;
        w = 16'hxxxx;
        if (obs_q.size() > 0) f = obs_q.pop_front();
        if (exp_q.size() > 0) w = exp_q.pop_front();
        check_output("serial_word", 32'(f.word), 32'(w));
        check_output("sclk_rises", 32'(f.nbits), 32'd16);
        check_output("cs_low_cycles", 32'(f.cs_low), 32'(1 + 32 * cd));
        check_output("sclk_high_cycles", 32'(f.sclk_hi), 32'(16 * cd));
        check_output("mosi_one_cycles", 32'(f.ones), 32'($countones(w) * 2 * cd + int'(w[15])));
        check_output("mosi_stable_high", 32'(f.unstable), 32'd0);
    endtask

    function automatic int fs_delta();
        if (fs_q.size() < 2) return -1;
        return int'(fs_q[1] - fs_q[0]);
    endfunction

    int ldac0;

    initial begin
        sel = 0;
        rst_n = 1'b0;
        if0.sample = '0; if1.sample = '0; if2.sample = '0;
        if0.enable = 1'b0; if1.enable = 1'b0; if2.enable = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_cs_n", 32'(m_cs_n), 32'd1);
        check_output("rst_sclk", 32'(m_sclk), 32'd0);
        check_output("rst_mosi", 32'(m_mosi), 32'd0);
        check_output("rst_ldac_n", 32'(m_ldac_n), 32'd1);
        check_output("rst_busy", 32'(m_busy), 32'd0);
        check_output("rst_frame_start", 32'(m_fs), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single frame A5C3, default parameters");
        apply_stimulus(16'hA5C3, 1'b1);
        set_enable(1'b1);
        @(negedge clk);
        check_output("load_frame_start", 32'(m_fs), 32'd1);
        check_output("load_cs_n", 32'(m_cs_n), 32'd0);
        check_output("load_busy", 32'(m_busy), 32'd1);
        check_output("load_mosi_msb", 32'(m_mosi), 32'd1);
        check_output("load_sclk", 32'(m_sclk), 32'd0);
        set_enable(1'b0);
        @(negedge clk);
        check_output("frame_start_width", 32'(m_fs), 32'd0);
        wait_obs(1, 200);
        check_frame(2);
        check_gap(4, 50);
        wait_idle(50);
        repeat (80) @(negedge clk);
        check_output("single_frame_count", 32'(fs_q.size()), 32'd1);
        flush();

        $display("[TB] back-to-back frames, sample changed mid-frame");
        apply_stimulus(16'h8000, 1'b1);
        set_enable(1'b1);
        repeat (20) @(negedge clk);
        apply_stimulus(16'h0000, 1'b1);
        wait_obs(2, 400);
        check_frame(2);
        check_frame(2);
        check_output("frame_period_default", 32'(fs_delta()), 32'd70);
        check_gap(4, 50);
        set_enable(1'b0);
        wait_idle(200);
        flush();

        $display("[TB] two's complement conversion");
        sel = 1;
        apply_stimulus(16'h8000, 1'b1);
        set_enable(1'b1);
        @(negedge clk);
        check_output("twos_load_frame_start", 32'(m_fs), 32'd1);
        check_output("twos_load_mosi", 32'(m_mosi), 32'd0);
        apply_stimulus(16'h7FFF, 1'b1);
        wait_obs(2, 400);
        check_frame(2);
        check_frame(2);
        set_enable(1'b0);
        wait_idle(200);
        flush();

        $display("[TB] CLK_DIV=1 GAP_CYC=1, all ones");
        sel = 2;
        apply_stimulus(16'hFFFF, 1'b1);
        apply_stimulus(16'hFFFF, 1'b1);
        set_enable(1'b1);
        wait_obs(2, 200);
        check_frame(1);
        check_frame(1);
        check_output("frame_period_fast", 32'(fs_delta()), 32'd35);
        check_gap(1, 20);
        set_enable(1'b0);
        wait_idle(100);
        flush();

        $display("[TB] enable dropped during bit 7");
        sel = 0;
        apply_stimulus(16'h1234, 1'b1);
        set_enable(1'b1);
        @(negedge clk);
        check_output("drop_load_frame_start", 32'(m_fs), 32'd1);
        repeat (29) @(negedge clk);
        ldac0 = ldac_cnt;
        set_enable(1'b0);
        wait_obs(1, 200);
        check_frame(2);
        check_gap(4, 50);
        wait_idle(50);
        repeat (100) @(negedge clk);
        check_output("drop_frame_count", 32'(fs_q.size()), 32'd1);
        check_output("drop_ldac_count", 32'(ldac_cnt - ldac0), 32'd1);
        flush();

        $display("[TB] reset during bit 10");
        apply_stimulus(16'h0F0F, 1'b0);
        set_enable(1'b1);
        @(negedge clk);
        check_output("abort_load_frame_start", 32'(m_fs), 32'd1);
        repeat (41) @(negedge clk);
        ldac0 = ldac_cnt;
        #1 rst_n = 1'b0;
        #1;
        check_output("abort_cs_n", 32'(m_cs_n), 32'd1);
        check_output("abort_sclk", 32'(m_sclk), 32'd0);
        check_output("abort_ldac_n", 32'(m_ldac_n), 32'd1);
        check_output("abort_busy", 32'(m_busy), 32'd0);
        check_output("abort_mosi", 32'(m_mosi), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check_output("abort_no_partial_frame", 32'(obs_q.size()), 32'd0);
        apply_stimulus(16'h3C5A, 1'b1);
        wait_obs(1, 200);
        set_enable(1'b0);
        check_frame(2);
        check_gap(4, 50);
        wait_idle(50);
        check_output("abort_ldac_count", 32'(ldac_cnt - ldac0), 32'd1);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Downstream stage of the waveform generators (sine/square/tan/etc.).
- Takes the selected 16-bit sample word and serializes it to an external 16-bit SPI DAC: chip-select framing, SCLK generation, MSB-first data and an LDAC update strobe.
- Emits a one-cycle frame_start pulse so the upstream generator can step its ROM address once per converted sample.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255.
- GAP_CYC, 4, clk cycles dac_cs_n is held high between the end of SHIFT and the LDAC pulse; legal range 1..255.
- TWOS_COMP, 0. If 1, the MSB of the latched word is inverted, converting offset-binary to two's complement.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sample  input  16  offset-binary sample from the generator; 32768 = mid-scale.
- enable  input  1  when high, frames run back-to-back; when low, the block idles after the current frame.
- frame_start  output  1  one-cycle pulse in the LOAD cycle.
- busy  output  1  high from LOAD through LDAC inclusive.
- dac_sclk  output  1  SPI clock; idles low; DAC samples on the rising edge.
- dac_cs_n  output  1  active-low chip select.
- dac_mosi  output  1  serial data, MSB first.
- dac_ldac_n  output  1  active-low DAC latch strobe.

Behaviour:
- Reset (async assert, any state): state=IDLE and all counters 0.
  - Output reset values: dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1, busy=0, frame_start=0.
  - Reset mid-frame aborts the frame immediately; no LDAC is issued.
- All outputs are registered. Deassertion of rst_n is assumed synchronous to clk (handled at top-level).
- FSM states: IDLE, LOAD, SHIFT, GAP, LDAC.
- IDLE: all outputs at reset values. If enable=1, go to LOAD next cycle.
- LOAD (1 cycle):
  - Latch the shift register from sample (MSB inverted if TWOS_COMP=1).
  - Drive dac_cs_n=0, dac_mosi=bit15 of the latched word, frame_start=1, busy=1. dac_sclk stays 0.
  - Go to SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1. At terminal count, dac_sclk toggles and the divider clears.
  - On each high-to-low toggle: shift left, dac_mosi takes the next bit, bit counter increments.
  - After the 16th falling edge, go to GAP with dac_sclk=0. Duration is exactly 32*CLK_DIV cycles.
  - dac_mosi is stable for the full high phase of each SCLK.
- GAP: dac_cs_n=1, dac_mosi=0. Hold for GAP_CYC cycles, then go to LDAC.
- LDAC (1 cycle): dac_ldac_n=0. Next state is LOAD if enable=1, else IDLE.
- Frame period with enable held: 1 + 32*CLK_DIV + GAP_CYC + 1 cycles. At defaults, 70 cycles.
- frame_start spacing equals the frame period.
- enable falling mid-frame: the frame completes, including LDAC, then the block goes to IDLE.
- enable rising mid-frame has no effect until the LDAC decision.
- sample changes after LOAD are ignored until the next LOAD.
- Simultaneous LDAC and enable=1: LOAD is entered the next cycle with no idle cycle; dac_cs_n returns low there.
- CLK_DIV=1: SCLK = clk/2. The same rules apply.

Test Plan:
- Reset, then enable=1, sample=16'hA5C3, defaults.
  - frame_start pulses 1 cycle after enable is sampled.
  - dac_cs_n low for 65 cycles; 16 SCLK rising edges capture 1010_0101_1100_0011.
  - dac_cs_n high 4 cycles, then dac_ldac_n low 1 cycle.
- enable held, sample=16'h8000 then 16'h0000 changed mid-frame.
  - frame_start period = 70 cycles.
  - The first frame shifts 8000; the change appears only in the next frame.
- TWOS_COMP=1, sample=16'h8000 -> serial word 16'h0000; sample=16'h7FFF -> 16'hFFFF.
- CLK_DIV=1, GAP_CYC=1, sample=16'hFFFF.
  - Frame period = 35 cycles; SCLK high/low 1 cycle each; dac_mosi=1 throughout SHIFT.
- enable dropped during bit 7, default parameters.
  - The frame finishes all 16 bits plus LDAC; then IDLE with busy=0; no further frame_start.
- rst_n asserted during SHIFT bit 10.
  - The same cycle gives dac_cs_n=1, dac_sclk=0, dac_ldac_n=1, busy=0.
  - After release with enable=1, a fresh full 16-bit frame is sent.
